// File: rtl/dma_csr_multi_if.sv
// Purpose: MMIO bus plus per-channel DMA engine handshake bundle for dma_csr_multi.
// Latency: n/a (wiring only).
// Backpressure: start requests use valid/ready; engines hold ready low to stall.
interface dma_csr_multi_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32
);
    // CPU MMIO side
    logic                     mmio_sel;
    logic [11:0]              mmio_addr;
    logic                     mmio_we;
    logic [63:0]              mmio_wdata;
    logic [63:0]              mmio_rdata;
    // DMA engine side
    logic [NUM_CH-1:0]        ch_start_valid;
    logic [NUM_CH-1:0]        ch_start_ready;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LEN_W-1:0]  ch_len;
    logic [NUM_CH-1:0]        ch_busy;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH-1:0]        ch_err;
    logic                     irq;

    // Environment view: CPU and engines drive requests, observe the block
    modport master (
        output mmio_sel, mmio_addr, mmio_we, mmio_wdata,
        output ch_start_ready, ch_busy, ch_done, ch_err,
        input  mmio_rdata, ch_start_valid, ch_addr, ch_len, irq
    );

    // CSR block view
    modport slave (
        input  mmio_sel, mmio_addr, mmio_we, mmio_wdata,
        input  ch_start_ready, ch_busy, ch_done, ch_err,
        output mmio_rdata, ch_start_valid, ch_addr, ch_len, irq
    );
endinterface

// File: rtl/dma_csr_multi.sv
// Purpose: NUM_CH-window MMIO CSR block: start handshake, sticky W1C flags, done counters, IRQ.
// Latency: reads combinational; writes and flag updates land at next edge; irq one cycle after flags.
// Backpressure: start valid holds until ready; START while pending or busy is dropped and flags OVR.
module dma_csr_multi #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rstn,
    dma_csr_multi_if.slave   bus
);
    localparam logic [63:0] ID_VAL = 64'h0000_0000_0001_0000 | 64'(NUM_CH);

    // Registers are 64-bit words; the byte-lane bits never select anything.
    logic [8:0] widx;
    logic [6:0] win;
    logic [1:0] rg;
    assign widx = bus.mmio_addr[11:3];
    assign win  = widx[8:2];
    assign rg   = widx[1:0];

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.mmio_addr[2:0];

    logic [NUM_CH-1:0]        irq_term;
    logic [NUM_CH-1:0]        valid_v;
    logic [NUM_CH*ADDR_W-1:0] addr_v;
    logic [NUM_CH*LEN_W-1:0]  len_v;
    logic [63:0]              rd_ch [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              hit, wr_ctrl, wr_addr, wr_len, wr_stat;
        logic              start_req, start_ok, zero_len;
        logic              ie_done, ie_err, pend, done_f, err_f, ovr_f;
        logic [ADDR_W-1:0] addr_r, snap_addr;
        logic [LEN_W-1:0]  len_r, snap_len;
        logic [CNT_W-1:0]  cnt;
        logic [63:0]       rd_word;

        assign hit       = bus.mmio_sel & bus.mmio_we & (win == 7'(c + 1));
        assign wr_ctrl   = hit & (rg == 2'd0);
        assign wr_addr   = hit & (rg == 2'd1);
        assign wr_len    = hit & (rg == 2'd2);
        assign wr_stat   = hit & (rg == 2'd3);
        assign start_req = wr_ctrl & bus.mmio_wdata[0];
        // A start is only taken when nothing is queued and the engine is idle
        assign start_ok  = start_req & ~pend & ~bus.ch_busy[c];
        assign zero_len  = (len_r == '0);

        // Channel register state; set pulses win over a same-cycle W1C
        always_ff @(posedge clk) begin
            if (!rstn) begin
                ie_done   <= 1'b0;
                ie_err    <= 1'b0;
                addr_r    <= '0;
                len_r     <= '0;
                snap_addr <= '0;
                snap_len  <= '0;
                pend      <= 1'b0;
                done_f    <= 1'b0;
                err_f     <= 1'b0;
                ovr_f     <= 1'b0;
                cnt       <= '0;
            end else begin
                if (wr_ctrl) begin
                    ie_done <= bus.mmio_wdata[1];
                    ie_err  <= bus.mmio_wdata[2];
                end
                if (wr_addr) addr_r <= bus.mmio_wdata[ADDR_W-1:0];
                if (wr_len)  len_r  <= bus.mmio_wdata[LEN_W-1:0];
                // Zero-length starts complete immediately and never reach the engine
                if (start_ok && !zero_len) begin
                    pend      <= 1'b1;
                    snap_addr <= addr_r;
                    snap_len  <= len_r;
                end else if (pend && bus.ch_start_ready[c]) begin
                    pend <= 1'b0;
                end
                done_f <= bus.ch_done[c] | (start_ok & zero_len)
                        | (done_f & ~(wr_stat & bus.mmio_wdata[2]));
                err_f  <= bus.ch_err[c] | (err_f & ~(wr_stat & bus.mmio_wdata[3]));
                ovr_f  <= (start_req & ~start_ok)
                        | (ovr_f & ~(wr_stat & bus.mmio_wdata[4]));
                cnt    <= cnt + CNT_W'(bus.ch_done[c]) + CNT_W'(start_ok & zero_len);
            end
        end

        // Register selected by the word offset inside this channel's window
        always_comb begin
            rd_word = '0;
            case (rg)
                2'd0: rd_word[2:0] = {ie_err, ie_done, 1'b0};
                2'd1: rd_word[ADDR_W-1:0] = addr_r;
                2'd2: rd_word[LEN_W-1:0] = len_r;
                default: begin
                    rd_word[4:0]        = {ovr_f, err_f, done_f, pend, bus.ch_busy[c]};
                    rd_word[16+:CNT_W]  = cnt;
                end
            endcase
        end

        assign rd_ch[c]                    = rd_word;
        assign irq_term[c]                 = (done_f & ie_done) | (err_f & ie_err);
        assign valid_v[c]                  = pend;
        assign addr_v[c*ADDR_W +: ADDR_W]  = snap_addr;
        assign len_v[c*LEN_W +: LEN_W]     = snap_len;
    end

    assign bus.ch_start_valid = valid_v;
    assign bus.ch_addr        = addr_v;
    assign bus.ch_len         = len_v;

    // Read mux: global registers, then channel windows; anything else reads 0
    logic [63:0] rdata;
    always_comb begin
        rdata = '0;
        if (widx == 9'd0) begin
            rdata = ID_VAL;
        end else if (widx == 9'd1) begin
            rdata = 64'(irq_term);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (win == 7'(c + 1)) rdata = rd_ch[c];
            end
        end
    end
    assign bus.mmio_rdata = rdata;

    // Level interrupt registered from the current flag/enable terms
    logic irq_r;
    always_ff @(posedge clk) begin
        if (!rstn) irq_r <= 1'b0;
        else       irq_r <= |irq_term;
    end
    assign bus.irq = irq_r;
endmodule

// File: tb/tb_dma_csr_multi.sv
// Purpose: directed scoreboard bench for dma_csr_multi (4 channels).
// Latency: expectations queued at posedge+1 are compared at the following negedge.
// Backpressure: engine ready/busy/done/err are driven directly by the stimulus.
module tb_dma_csr_multi;
    logic clk;
    logic rstn;

    dma_csr_multi_if #(.NUM_CH(4), .ADDR_W(64), .LEN_W(32)) bus ();

    dma_csr_multi #(.NUM_CH(4), .ADDR_W(64), .LEN_W(32), .CNT_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation kinds
    localparam int K_RDATA = 0;
    localparam int K_VALID = 1;
    localparam int K_IRQ   = 2;
    localparam int K_ADDR0 = 3;
    localparam int K_LEN0  = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] exp;
    } chk_t;

    chk_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_RDATA: return bus.mmio_rdata;
            K_VALID: return 64'(bus.ch_start_valid);
            K_IRQ:   return 64'(bus.irq);
            K_ADDR0: return bus.ch_addr[63:0];
            default: return 64'(bus.ch_len[31:0]);
        endcase
    endfunction

    // Monitor: drain every expectation queued during this cycle
    initial begin
        chk_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = observe(e.kind);
                n_total++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got 0x%h expected 0x%h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string n, input int k, input logic [63:0] e);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.exp  = e;
        sbq.push_back(c);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        bus.mmio_sel   = 1'b1;
        bus.mmio_we    = 1'b1;
        bus.mmio_addr  = a;
        bus.mmio_wdata = d;
        tick();
        bus.mmio_sel   = 1'b0;
        bus.mmio_we    = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input string n, input logic [63:0] e);
        bus.mmio_sel  = 1'b1;
        bus.mmio_we   = 1'b0;
        bus.mmio_addr = a;
        expect_v(n, K_RDATA, e);
        tick();
        bus.mmio_sel  = 1'b0;
    endtask

    initial begin
        rstn               = 1'b0;
        bus.mmio_sel       = 1'b0;
        bus.mmio_we        = 1'b0;
        bus.mmio_addr      = '0;
        bus.mmio_wdata     = '0;
        bus.ch_start_ready = '0;
        bus.ch_busy        = '0;
        bus.ch_done        = '0;
        bus.ch_err         = '0;

        // 1. Reset
        tick();
        expect_v("rst_valid", K_VALID, 64'h0);
        expect_v("rst_irq",   K_IRQ,   64'h0);
        tick();
        rstn = 1'b1;
        expect_v("rst_addr0", K_ADDR0, 64'h0);
        rd(12'h000, "id", 64'h0000_0000_0001_0004);
        rd(12'h038, "rst_stat0", 64'h0);
        rd(12'h010, "unmapped_10", 64'h0);

        // 2. Ch0 start with held-off ready; snapshot must not follow ADDR rewrite
        wr(12'h028, 64'h8000);
        wr(12'h030, 64'h3);
        wr(12'h020, 64'h1);
        for (int i = 0; i < 5; i++) begin
            expect_v("ch0_valid_hold", K_VALID, 64'h1);
            expect_v("ch0_addr_hold",  K_ADDR0, 64'h8000);
            expect_v("ch0_len_hold",   K_LEN0,  64'h3);
            if (i == 1)      wr(12'h028, 64'h9000);
            else if (i == 3) rd(12'h038, "ch0_stat_pend", 64'h2);
            else             tick();
        end
        bus.ch_start_ready[0] = 1'b1;
        expect_v("ch0_valid_hs", K_VALID, 64'h1);
        tick();
        bus.ch_start_ready[0] = 1'b0;
        expect_v("ch0_valid_drop", K_VALID, 64'h0);
        rd(12'h038, "ch0_stat_idle", 64'h0);
        // Write without select must be ignored
        bus.mmio_we = 1'b1; bus.mmio_addr = 12'h028; bus.mmio_wdata = 64'h1234;
        tick();
        bus.mmio_we = 1'b0;
        rd(12'h028, "ch0_addr_nosel", 64'h9000);
        wr(12'h0A0, 64'h7);
        rd(12'h0A0, "unmapped_ch4", 64'h0);

        // 3. Ch1 done interrupt and W1C
        wr(12'h050, 64'h5);
        wr(12'h040, 64'h3);
        expect_v("ch1_valid", K_VALID, 64'h2);
        rd(12'h040, "ch1_ctrl", 64'h2);
        bus.ch_start_ready[1] = 1'b1;
        tick();
        bus.ch_start_ready[1] = 1'b0;
        bus.ch_busy[1] = 1'b1;
        expect_v("ch1_valid_drop", K_VALID, 64'h0);
        tick();
        tick();
        bus.ch_done[1] = 1'b1;
        bus.ch_busy[1] = 1'b0;
        tick();
        bus.ch_done[1] = 1'b0;
        expect_v("ch1_irq_lag", K_IRQ, 64'h0);
        rd(12'h008, "irq_stat", 64'h2);
        expect_v("ch1_irq_set", K_IRQ, 64'h1);
        rd(12'h058, "ch1_stat_done", 64'h1_0004);
        expect_v("ch1_irq_w1c_cyc", K_IRQ, 64'h1);
        wr(12'h058, 64'h4);
        expect_v("ch1_irq_after_w1c", K_IRQ, 64'h1);
        rd(12'h058, "ch1_stat_clr", 64'h1_0000);
        expect_v("ch1_irq_clr", K_IRQ, 64'h0);
        tick();
        bus.ch_done[1] = 1'b1;
        bus.ch_err[1]  = 1'b1;
        tick();
        bus.ch_done[1] = 1'b0;
        bus.ch_err[1]  = 1'b0;
        rd(12'h058, "ch1_done_err", 64'h2_000C);
        wr(12'h058, 64'hC);
        rd(12'h058, "ch1_w1c_both", 64'h2_0000);

        // 4. Ch2 overrun while busy, zero-length start, overrun while pending
        bus.ch_busy[2] = 1'b1;
        wr(12'h070, 64'h7);
        wr(12'h060, 64'h1);
        expect_v("ch2_busy_novalid", K_VALID, 64'h0);
        rd(12'h078, "ch2_ovr", 64'h11);
        bus.ch_busy[2] = 1'b0;
        wr(12'h078, 64'h10);
        wr(12'h070, 64'h0);
        wr(12'h060, 64'h1);
        expect_v("ch2_zlen_novalid", K_VALID, 64'h0);
        rd(12'h078, "ch2_zlen_done", 64'h1_0004);
        wr(12'h070, 64'h7);
        wr(12'h060, 64'h1);
        wr(12'h060, 64'h1);
        expect_v("ch2_valid", K_VALID, 64'h4);
        rd(12'h078, "ch2_pend_ovr", 64'h1_0016);
        bus.ch_start_ready[2] = 1'b1;
        tick();
        bus.ch_start_ready[2] = 1'b0;

        // 5. Ch3 counter wrap and set-beats-W1C
        bus.ch_done[3] = 1'b1;
        repeat (65535) tick();
        bus.ch_done[3] = 1'b0;
        rd(12'h098, "ch3_cnt_max", 64'hFFFF_0004);
        bus.ch_done[3] = 1'b1;
        tick();
        bus.ch_done[3] = 1'b0;
        rd(12'h098, "ch3_cnt_wrap", 64'h0000_0004);
        bus.ch_done[3] = 1'b1;
        wr(12'h098, 64'h4);
        bus.ch_done[3] = 1'b0;
        rd(12'h098, "ch3_set_wins", 64'h1_0004);
        wr(12'h098, 64'h4);
        rd(12'h098, "ch3_w1c", 64'h1_0000);

        // 6. Reset mid-operation
        wr(12'h020, 64'h1);
        bus.ch_done[1] = 1'b1;
        tick();
        bus.ch_done[1] = 1'b0;
        tick();
        expect_v("pre_rst_valid", K_VALID, 64'h1);
        expect_v("pre_rst_irq",   K_IRQ,   64'h1);
        expect_v("pre_rst_addr0", K_ADDR0, 64'h9000);
        rd(12'h058, "pre_rst_ch1", 64'h3_0004);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        expect_v("post_rst_valid", K_VALID, 64'h0);
        expect_v("post_rst_irq",   K_IRQ,   64'h0);
        expect_v("post_rst_addr0", K_ADDR0, 64'h0);
        rd(12'h058, "post_rst_ch1", 64'h0);
        rd(12'h038, "post_rst_ch0", 64'h0);

        tick();
        tick();
        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
            n_total += sbq.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
